// File: rtl/change_dispenser.sv
// Coin-return payout engine: pays an amount out greedily as 2-unit then 1-unit coins
// over a req/ack hopper handshake. Optional ack watchdog when DISPENSE_TIMEOUT_EN is defined.
module change_dispenser #(
    parameter int CHG_W       = 3,
    parameter int COIN_GAP    = 2,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CHG_W-1:0] change,
    input  logic             coin_ack,
    input  logic             hop1_empty,
    input  logic             hop2_empty,
    input  logic             fault_clr,
    output logic             busy,
    output logic             coin_req,
    output logic             coin_sel,
    output logic             done,
    output logic             fault,
    output logic [CHG_W-1:0] owed
);

    localparam int GAP_W = (COIN_GAP > 1) ? $clog2(COIN_GAP) : 1;

    if (CHG_W < 2 || ACK_TIMEOUT < 1) begin : g_bad_param
        $error("change_dispenser: CHG_W must be >= 2 and ACK_TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        REQ,
        WAIT_ACK,
        GAP,
        FAULT
    } state_t;

    state_t           state, state_nx;
    logic             coin_req_nx, coin_sel_nx, done_nx;
    logic [CHG_W-1:0] owed_nx;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_nx;
    logic [CHG_W-1:0] coin_val, owed_after;

`ifdef DISPENSE_TIMEOUT_EN
    localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    logic [TO_W-1:0] to_cnt, to_cnt_nx;
`endif

    // Greedy selection in SELECT guarantees coin_val <= owed, so no underflow.
    assign coin_val   = coin_sel ? CHG_W'(2) : CHG_W'(1);
    assign owed_after = owed - coin_val;

    assign busy  = (state != IDLE) && (state != FAULT);
    assign fault = (state == FAULT);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_nx    = state;
        coin_req_nx = coin_req;
        coin_sel_nx = coin_sel;
        done_nx     = 1'b0;
        owed_nx     = owed;
        gap_cnt_nx  = gap_cnt;
`ifdef DISPENSE_TIMEOUT_EN
        to_cnt_nx   = to_cnt;
`endif
        case (state)
            IDLE: begin
                if (load) begin
                    if (change != '0) begin
                        owed_nx  = change;
                        state_nx = SELECT;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            SELECT: begin
                // Never overpay: a lone unit owed with no 1-unit coins is a fault.
                if (owed >= CHG_W'(2) && !hop2_empty) begin
                    coin_sel_nx = 1'b1;
                    state_nx    = REQ;
                end else if (!hop1_empty) begin
                    coin_sel_nx = 1'b0;
                    state_nx    = REQ;
                end else begin
                    state_nx = FAULT;
                end
            end
            REQ: begin
                coin_req_nx = 1'b1;
                state_nx    = WAIT_ACK;
`ifdef DISPENSE_TIMEOUT_EN
                to_cnt_nx   = '0;
`endif
            end
            WAIT_ACK: begin
                if (coin_ack) begin
                    coin_req_nx = 1'b0;
                    owed_nx     = owed_after;
                    if (COIN_GAP > 0) begin
                        gap_cnt_nx = '0;
                        state_nx   = GAP;
                    end else if (owed_after == '0) begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = SELECT;
                    end
                end
`ifdef DISPENSE_TIMEOUT_EN
                else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
                    coin_req_nx = 1'b0;
                    state_nx    = FAULT;
                end else begin
                    to_cnt_nx = to_cnt + 1'b1;
                end
`endif
            end
            GAP: begin
                if (gap_cnt == GAP_W'(COIN_GAP - 1)) begin
                    if (owed == '0) begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = SELECT;
                    end
                end else begin
                    gap_cnt_nx = gap_cnt + 1'b1;
                end
            end
            FAULT: begin
                // fault_clr wins over a simultaneous load; the load is simply dropped.
                if (fault_clr) begin
                    owed_nx  = '0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state    <= IDLE;
            coin_req <= 1'b0;
            coin_sel <= 1'b0;
            done     <= 1'b0;
            owed     <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_nx;
            coin_req <= coin_req_nx;
            coin_sel <= coin_sel_nx;
            done     <= done_nx;
            owed     <= owed_nx;
            gap_cnt  <= gap_cnt_nx;
        end
    end

`ifdef DISPENSE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) to_cnt <= '0;
        else     to_cnt <= to_cnt_nx;
    end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser: a transaction-level payout model drives the
// expected outputs, one negedge process compares them every cycle.
module tb_change_dispenser;

    localparam int CHG_W    = 3;
    localparam int COIN_GAP = 2;

    logic             clk = 1'b0;
    logic             rst, load, coin_ack, hop1_empty, hop2_empty, fault_clr;
    logic [CHG_W-1:0] change;
    logic             busy, coin_req, coin_sel, done, fault;
    logic [CHG_W-1:0] owed;

    change_dispenser #(
        .CHG_W      (CHG_W),
        .COIN_GAP   (COIN_GAP),
        .ACK_TIMEOUT(64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .change    (change),
        .coin_ack  (coin_ack),
        .hop1_empty(hop1_empty),
        .hop2_empty(hop2_empty),
        .fault_clr (fault_clr),
        .busy      (busy),
        .coin_req  (coin_req),
        .coin_sel  (coin_sel),
        .done      (done),
        .fault     (fault),
        .owed      (owed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected outputs after the most recent rising edge.
    logic             exp_busy = 0, exp_req = 0, exp_sel = 0, exp_done = 0, exp_fault = 0;
    logic [CHG_W-1:0] exp_owed = '0;
    bit               chk_en = 0;

    logic             sel_q[$];
    int               done_cnt = 0;
    int               fault_owed = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",     busy,     exp_busy);
            check("coin_req", coin_req, exp_req);
            check("coin_sel", coin_sel, exp_sel);
            check("done",     done,     exp_done);
            check("fault",    fault,    exp_fault);
            check("owed",     owed,     exp_owed);
        end
        if (done === 1'b1) done_cnt++;
        if (fault === 1'b1) fault_owed = int'(owed);
    end

    always @(posedge clk) begin
        if (!rst && coin_req === 1'b1 && coin_ack === 1'b1) sel_q.push_back(coin_sel);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected coin value under the greedy, no-overpay rule; 0 means no legal coin.
    function automatic int pick_coin(input int amt, input logic h1e, input logic h2e);
        if (amt >= 2 && !h2e) return 2;
        if (!h1e)             return 1;
        return 0;
    endfunction

    // mode: 0 random hopper flags per coin, 1 both full, 2 hop2 empty, 3 only hop1 empty
    task automatic run_txn(input int chg, input int mode, input int max_delay);
        int   owed_m, val, d;
        logic h1e, h2e;
        load     = 1'b1;
        change   = CHG_W'(chg);
        coin_ack = 1'($urandom);
        tick();
        load     = 1'b0;
        coin_ack = 1'b0;
        if (chg == 0) begin
            exp_done = 1'b1;
            tick();
            exp_done = 1'b0;
            return;
        end
        owed_m   = chg;
        exp_owed = CHG_W'(owed_m);
        exp_busy = 1'b1;
        forever begin
            case (mode)
                1:       begin h1e = 1'b0; h2e = 1'b0; end
                2:       begin h1e = 1'b0; h2e = 1'b1; end
                3:       begin h1e = 1'b1; h2e = 1'b0; end
                default: begin h1e = ($urandom_range(0, 7) == 0); h2e = ($urandom_range(0, 2) == 0); end
            endcase
            hop1_empty = h1e;
            hop2_empty = h2e;
            coin_ack   = 1'($urandom);
            val        = pick_coin(owed_m, h1e, h2e);
            tick();
            hop1_empty = 1'($urandom);
            hop2_empty = 1'($urandom);
            if (val == 0) begin
                exp_fault = 1'b1;
                exp_busy  = 1'b0;
                repeat ($urandom_range(1, 4)) begin
                    load     = 1'($urandom);
                    change   = CHG_W'($urandom);
                    coin_ack = 1'($urandom);
                    tick();
                end
                fault_clr = 1'b1;
                load      = 1'($urandom);
                tick();
                fault_clr = 1'b0;
                load      = 1'b0;
                coin_ack  = 1'b0;
                exp_fault = 1'b0;
                exp_owed  = '0;
                return;
            end
            exp_sel = (val == 2);
            tick();
            coin_ack = 1'b0;
            exp_req  = 1'b1;
            d = $urandom_range(0, max_delay);
            repeat (d) begin
                load       = ($urandom_range(0, 3) == 0);
                change     = CHG_W'($urandom);
                hop1_empty = 1'($urandom);
                hop2_empty = 1'($urandom);
                tick();
            end
            load     = 1'b0;
            coin_ack = 1'b1;
            tick();
            coin_ack = 1'b0;
            exp_req  = 1'b0;
            owed_m  -= val;
            exp_owed = CHG_W'(owed_m);
            // After the ack: COIN_GAP gap cycles, then SELECT (or IDLE when nothing is owed).
            repeat (COIN_GAP) begin
                coin_ack = 1'($urandom);
                tick();
            end
            coin_ack = 1'b0;
            if (owed_m == 0) begin
                exp_done = 1'b1;
                exp_busy = 1'b0;
                tick();
                exp_done = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        int d0;
        rst = 1'b1; load = 1'b0; change = '0; coin_ack = 1'b0;
        hop1_empty = 1'b0; hop2_empty = 1'b0; fault_clr = 1'b0;
        tick();
        chk_en = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_req",  coin_req, 0);
        check("rst_owed", owed, 0);
        tick();
        rst = 1'b0;
        tick();

        // 3 units, both hoppers full: a 2-unit coin then a 1-unit coin, one done.
        sel_q.delete(); d0 = done_cnt;
        run_txn(3, 1, 1);
        check("t1_coins", sel_q.size(), 2);
        if (sel_q.size() == 2) begin
            check("t1_first_sel",  sel_q[0], 1);
            check("t1_second_sel", sel_q[1], 0);
        end
        check("t1_done_cnt", done_cnt - d0, 1);

        // 4 units, 2-unit hopper empty: four 1-unit coins.
        sel_q.delete(); d0 = done_cnt;
        run_txn(4, 2, 2);
        check("t2_coins", sel_q.size(), 4);
        check("t2_ones",  sel_q.sum() with (int'(item)), 0);
        check("t2_done_cnt", done_cnt - d0, 1);

        // 1 unit with only 2-unit coins available: fault without paying.
        sel_q.delete(); fault_owed = -1;
        run_txn(1, 3, 1);
        check("t3_coins", sel_q.size(), 0);
        check("t3_fault_owed", fault_owed, 1);

        // Zero change: immediate done, no coin.
        sel_q.delete(); d0 = done_cnt;
        run_txn(0, 1, 1);
        check("t4_coins", sel_q.size(), 0);
        check("t4_done_cnt", done_cnt - d0, 1);

        // A long withheld ack must simply be waited out in the default build.
        run_txn(2, 1, 80);

        // Reset while a request is outstanding.
        hop1_empty = 1'b0; hop2_empty = 1'b0;
        load = 1'b1; change = CHG_W'(5);
        tick();
        load = 1'b0; exp_owed = CHG_W'(5); exp_busy = 1'b1;
        tick();
        exp_sel = 1'b1;
        tick();
        exp_req = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        exp_busy = 0; exp_req = 0; exp_sel = 0; exp_owed = '0;
        check("t5_req_after_rst",  coin_req, 0);
        check("t5_busy_after_rst", busy, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 40; i++) begin
            run_txn($urandom_range(0, (1 << CHG_W) - 1), 0, 3);
            repeat ($urandom_range(0, 2)) begin
                coin_ack  = 1'($urandom);
                fault_clr = 1'($urandom);
                tick();
            end
            coin_ack  = 1'b0;
            fault_clr = 1'b0;
        end

        tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
